// File: rtl/mfp_ahb_uart_loader_master.sv
// Byte-stream loader: parses {base, count, payload words} and writes each word
// to program RAM as a single non-overlapped AHB-Lite 32-bit write.
module mfp_ahb_uart_loader_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        loading,
    output logic        done,
    output logic        overflow,
    output logic        bus_error
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {H_ADDR, H_COUNT, P_DATA} pstate_t;
    typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bstate_t;

    pstate_t     pstate, pstate_next;
    bstate_t     bstate, bstate_next;
    logic [1:0]  byte_cnt;
    logic [31:0] shreg, word_addr, count, idle_cnt;
    logic [31:0] field_word;
    logic        in_frame, field_done, timeout, frame_start;
    logic        push_req, last_word, zero_frame, do_push, drop, pop, drain_last;
    logic        end_pending;

    logic [31:0] mem_addr [FIFO_DEPTH];
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fcnt;
    logic          fifo_empty;

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HSIZE     = 3'b010;
    assign HTRANS    = (bstate == B_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE    = (bstate == B_ADDR);

    assign field_word  = {shreg[23:0], rx_byte};
    assign in_frame    = (pstate != H_ADDR) || (byte_cnt != 2'd0);
    assign field_done  = rx_valid && (byte_cnt == 2'd3);
    assign frame_start = rx_valid && (pstate == H_ADDR) && (byte_cnt == 2'd0);
    assign timeout     = TO_EN && in_frame && !rx_valid && (idle_cnt == TO_LAST);
    assign push_req    = field_done && (pstate == P_DATA);
    assign last_word   = push_req && (count == 32'd1);
    assign zero_frame  = field_done && (pstate == H_COUNT) && (field_word == 32'd0);

    assign fifo_empty  = (fcnt == '0);
    assign do_push     = push_req && ((fcnt != FULL_CNT) || pop);
    assign drop        = push_req && !do_push;
    // The frame's final word may have been dropped, so completion is tracked
    // as "frame ended and the FIFO has just drained".
    assign drain_last  = end_pending && pop && (fcnt == ONE_CNT) && !do_push;
    assign loading     = in_frame || !fifo_empty || (bstate != B_IDLE);

    always_comb begin
        pstate_next = pstate;
        if (timeout) begin
            pstate_next = H_ADDR;
        end else if (field_done) begin
            case (pstate)
                H_ADDR:  pstate_next = H_COUNT;
                H_COUNT: pstate_next = (field_word == 32'd0) ? H_ADDR : P_DATA;
                P_DATA:  pstate_next = (count == 32'd1) ? H_ADDR : P_DATA;
                default: pstate_next = H_ADDR;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pstate   <= H_ADDR;
            byte_cnt <= 2'd0;
            idle_cnt <= 32'd0;
        end else begin
            pstate <= pstate_next;
            if (timeout)
                byte_cnt <= 2'd0;
            else if (rx_valid)
                byte_cnt <= byte_cnt + 2'd1;
            if (rx_valid || !in_frame || timeout)
                idle_cnt <= 32'd0;
            else
                idle_cnt <= idle_cnt + 32'd1;
        end
    end

    // Parser datapath: assembled fields and the running write address
    always_ff @(posedge HCLK) begin
        if (rx_valid)
            shreg <= field_word;
        if (field_done && pstate == H_ADDR)
            word_addr <= {field_word[31:2], 2'b00};
        if (field_done && pstate == H_COUNT)
            count <= field_word;
        if (push_req) begin
            word_addr <= word_addr + 32'd4;
            count     <= count - 32'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= word_addr;
            mem_data[wr_ptr] <= field_word;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    always_comb begin
        bstate_next = bstate;
        pop         = 1'b0;
        case (bstate)
            B_IDLE: if (!fifo_empty) bstate_next = B_ADDR;
            B_ADDR: if (HREADY) bstate_next = B_DATA;
            B_DATA: begin
                if (HREADY) begin
                    pop         = 1'b1;
                    bstate_next = B_IDLE;
                end
            end
            default: bstate_next = B_IDLE;
        endcase
    end

    // Bus stage: address captured entering B_ADDR, data entering B_DATA
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bstate <= B_IDLE;
            HADDR  <= 32'd0;
            HWDATA <= 32'd0;
        end else begin
            bstate <= bstate_next;
            if (bstate == B_IDLE && !fifo_empty)
                HADDR <= mem_addr[rd_ptr];
            if (bstate == B_ADDR && HREADY)
                HWDATA <= mem_data[rd_ptr];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            done        <= 1'b0;
            overflow    <= 1'b0;
            bus_error   <= 1'b0;
            end_pending <= 1'b0;
        end else begin
            if (frame_start) begin
                done      <= 1'b0;
                overflow  <= 1'b0;
                bus_error <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            if (bstate == B_DATA && HRESP)
                bus_error <= 1'b1;
            if (zero_frame)
                done <= 1'b1;
            if (last_word)
                end_pending <= 1'b1;
            if (drain_last) begin
                done        <= 1'b1;
                end_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mfp_ahb_uart_loader_master.md
# mfp_ahb_uart_loader_master

Upstream AHB-Lite write master that fills program RAM from a received byte stream, typically UART receiver output, so that the RAM slave serves the downloaded image instead of its built-in fallback program. It parses a fixed 8-byte header (start address, word count) followed by big-endian payload words. Payload words are buffered in a small FIFO and issued to the bus as single, non-overlapped 32-bit write transfers.

## Interface
Parameters:
- FIFO_DEPTH, 4, payload word buffer depth; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 1000000, idle cycles between bytes after which a partial frame is abandoned; 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- HADDR  out  32  transfer address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant 4'b0011.
- HSIZE  out  3  constant 3'b010 (word).
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWDATA  out  32  write data.
- HWRITE  out  1  write indicator.
- HREADY  in  1  bus ready.
- HRESP  in  1  bus error response.
- loading  out  1  frame in progress, or FIFO not empty, or a bus transfer pending.
- done  out  1  sticky; the last word of a complete frame has been written.
- overflow  out  1  sticky; a payload word was dropped.
- bus_error  out  1  sticky; HRESP=1 was seen in a data phase.

## Operation
- Reset values: all outputs 0, except the constant outputs, which hold their constant values. Parser state is H_ADDR, the FIFO is empty, and the bus FSM is IDLE.
- Parser FSM, which advances on each rx_valid:
  - H_ADDR: collect 4 bytes, MSB first, into base. The low 2 bits are forced to 0.
  - H_COUNT: collect 4 bytes, MSB first, into count.
    - If count is 0, go to H_ADDR and set done.
    - Otherwise go to P_DATA.
  - P_DATA: collect 4 bytes, MSB first, into a word, then push it to the FIFO and decrement count. When count reaches 0, return to H_ADDR.
- The first header byte of a frame clears done, overflow and bus_error.
- A push into a full FIFO drops the word and sets overflow. The count still decrements and the address still advances, so later words land at their correct addresses.
- Each FIFO entry holds its own address. The address starts at base and increments by 4 per word; it is 32 bits wide and wraps from 0xFFFFFFFC to 0.
- Timeout: a byte counter inside the current field that is nonzero, or parser state not H_ADDR, with TIMEOUT_CYCLES cycles elapsed and no rx_valid, sends the parser to H_ADDR and discards the partial word. Words already in the FIFO are still written. done is not set.
- Bus FSM:
  - B_IDLE: HTRANS=IDLE. If the FIFO is not empty, go to B_ADDR.
  - B_ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=head address, all held stable until sampled with HREADY=1; then go to B_DATA.
  - B_DATA: HTRANS=IDLE, HWRITE=0, HWDATA=head data, held until HREADY=1. On that edge, pop the FIFO and go to B_IDLE.
  - If HRESP=1 in B_DATA, set bus_error. The word is still popped and not retried.
- done is set when the final payload word completes its data phase, or immediately for count=0.
- rx_valid is accepted in every state, with no backpressure. A push and a pop in the same cycle are both honoured.

## Timing
- Minimum of 3 cycles per word with HREADY tied high: B_IDLE, then B_ADDR, then B_DATA.
- Last payload byte at cycle T, on an empty FIFO and idle bus:
  - FIFO non-empty at T+1.
  - NONSEQ driven at T+2.
  - HWDATA valid at T+3.
  - done and loading=0 at T+4.
- HWDATA changes only on entry to B_DATA, never mid-data-phase.
- A reset mid-transfer returns everything to reset values on the next evaluation, asynchronously. The partially written word is not guaranteed.
- Sustained input is lossless while bytes arrive no faster than 1 per cycle averaged over 4 bytes per 3 cycles, given HREADY=1. Faster input, or a stalling bus, relies on FIFO_DEPTH.

## Test plan
- Frame 1FC00000 / 00000002 / 00001825 00002825, HREADY=1:
  - writes 0x00001825 to 0x1FC00000 and 0x00002825 to 0x1FC00004;
  - HTRANS=NONSEQ exactly twice;
  - done=1, loading=0.
- Header base 0x1FC00003: the first write goes to 0x1FC00000. Base 0xFFFFFFFC with count 2: writes go to 0xFFFFFFFC, then 0x00000000.
- HREADY held low for 5 cycles in B_ADDR and again in B_DATA: HADDR, HTRANS and HWDATA are stable throughout, and there is exactly one pop per word.
- FIFO_DEPTH=2, HREADY=0 for a long time, 4-word frame at 1 byte per cycle:
  - overflow=1;
  - after HREADY=1, words 0 and 1 are written at base and base+4;
  - done=1.
- TIMEOUT_CYCLES=16:
  - send 6 header bytes, then stay idle for 20 cycles, then send a valid frame;
  - the second frame is parsed correctly, and no write occurs for the first.
- HRESP=1 on the first data phase of a 2-word frame: bus_error=1, the second word is still written, done=1. Asserting reset in mid-frame drives all outputs to 0.
